// File: rtl/mac_result_collector.sv
// Collects one complex MAC result per select value into a 2-bank ping-pong
// frame buffer and streams completed frames out over valid/ready.
//
// Write FSM states:
//   state | meaning
//   HUNT  | waiting for sel_in==0 to start a frame; other selects ignored
//   FILL  | capturing entries in order; exp holds the next expected select
module mac_result_collector #(
    parameter int DW        = 16,
    parameter int SEL_W     = 3,
    parameter int FRAME_LEN = 5
) (
    input  logic             clk2,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             res_valid,
    input  logic [DW-1:0]    res_re,
    input  logic [DW-1:0]    res_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] out_idx,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic             out_last,
    output logic             seq_err,
    output logic             overflow
);

    typedef enum logic {HUNT, FILL} wr_state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(FRAME_LEN - 1);

    wr_state_t        state, state_nxt;
    logic [SEL_W-1:0] exp_q, exp_nxt;
    logic [SEL_W-1:0] rd_idx;
    logic [1:0]       full, full_nxt;
    logic             wr_bank, rd_bank;
    logic             we, set_full, wr_full;
    logic [SEL_W-1:0] we_idx;
    logic             seq_err_nxt, overflow_nxt;
    logic             rd_hs;

    logic [DW-1:0] mem_re [2][FRAME_LEN];
    logic [DW-1:0] mem_im [2][FRAME_LEN];

    assign wr_full = full[wr_bank];

    always_comb begin
        state_nxt    = state;
        exp_nxt      = exp_q;
        we           = 1'b0;
        we_idx       = exp_q;
        set_full     = 1'b0;
        seq_err_nxt  = 1'b0;
        overflow_nxt = 1'b0;
        if (res_valid) begin
            case (state)
                HUNT: begin
                    if (sel_in == '0) begin
                        if (wr_full) begin
                            overflow_nxt = 1'b1;
                        end else begin
                            we        = 1'b1;
                            we_idx    = '0;
                            exp_nxt   = SEL_W'(1);
                            state_nxt = FILL;
                        end
                    end
                end
                FILL: begin
                    if (sel_in == exp_q) begin
                        // exp==0 here means a fresh frame is starting right after a completed one
                        if (exp_q == '0 && wr_full) begin
                            overflow_nxt = 1'b1;
                            exp_nxt      = '0;
                            state_nxt    = HUNT;
                        end else begin
                            we = 1'b1;
                            if (exp_q == LAST_IDX) begin
                                set_full = 1'b1;
                                exp_nxt  = '0;
                            end else begin
                                exp_nxt = exp_q + SEL_W'(1);
                            end
                        end
                    end else begin
                        seq_err_nxt = 1'b1;
                        if (sel_in == '0 && !wr_full) begin
                            we      = 1'b1;
                            we_idx  = '0;
                            exp_nxt = SEL_W'(1);
                        end else begin
                            exp_nxt   = '0;
                            state_nxt = HUNT;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign out_valid = full[rd_bank];
    assign rd_hs     = out_valid & out_ready;
    assign out_last  = out_valid && (rd_idx == LAST_IDX);
    assign out_idx   = rd_idx;
    assign out_re    = out_valid ? mem_re[rd_bank][rd_idx] : '0;
    assign out_im    = out_valid ? mem_im[rd_bank][rd_idx] : '0;

    always_comb begin
        full_nxt = full;
        if (rd_hs && out_last) full_nxt[rd_bank] = 1'b0;
        if (set_full)          full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            exp_q    <= '0;
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            rd_idx   <= '0;
            seq_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            exp_q    <= exp_nxt;
            full     <= full_nxt;
            seq_err  <= seq_err_nxt;
            overflow <= overflow_nxt;
            if (set_full) wr_bank <= ~wr_bank;
            if (rd_hs) begin
                if (out_last) begin
                    rd_idx  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_idx <= rd_idx + SEL_W'(1);
                end
            end
        end
    end

    // Data storage needs no reset: the full flags gate everything visible.
    always_ff @(posedge clk2) begin
        if (we) begin
            mem_re[wr_bank][we_idx] <= res_re;
            mem_im[wr_bank][we_idx] <= res_im;
        end
    end

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector: queue-based frame model compared
// every cycle, directed scenarios pinned by literal expectations, then random traffic.
module tb_mac_result_collector;

    localparam int DW = 16;
    localparam int SEL_W = 3;
    localparam int FL = 5;

    logic             clk2 = 1'b0;
    logic             rst = 1'b1;
    logic [SEL_W-1:0] sel_in = '0;
    logic             res_valid = 1'b0;
    logic [DW-1:0]    res_re = '0;
    logic [DW-1:0]    res_im = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SEL_W-1:0] out_idx;
    logic [DW-1:0]    out_re;
    logic [DW-1:0]    out_im;
    logic             out_last;
    logic             seq_err;
    logic             overflow;

    mac_result_collector #(.DW(DW), .SEL_W(SEL_W), .FRAME_LEN(FL)) dut (
        .clk2(clk2), .rst(rst), .sel_in(sel_in), .res_valid(res_valid),
        .res_re(res_re), .res_im(res_im), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_re(out_re), .out_im(out_im), .out_last(out_last),
        .seq_err(seq_err), .overflow(overflow)
    );

    always #10 clk2 = ~clk2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_se = 0;
    int n_ov = 0;
    logic [35:0] log_q[$];
    int          stamp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Behavioural model: completed frames live in a queue of entries, the head
    // frame being drained; a frame under construction is a separate list.
    logic [31:0] fq[$];
    logic [31:0] part[$];
    bit          m_hunt = 1'b1;
    int          rd_pos = 0;
    bit          m_se = 1'b0;
    bit          m_ov = 1'b0;
    int          n0;
    bit          push_frame;

    always @(posedge clk2 or posedge rst) begin
        if (rst) begin
            fq.delete();
            part.delete();
            m_hunt = 1'b1;
            rd_pos = 0;
            m_se = 1'b0;
            m_ov = 1'b0;
        end else begin
            cyc++;
            n0 = fq.size() / FL;
            m_se = 1'b0;
            m_ov = 1'b0;
            push_frame = 1'b0;
            if (res_valid) begin
                if (m_hunt) begin
                    if (sel_in == 0) begin
                        if (n0 == 2) m_ov = 1'b1;
                        else begin
                            part.push_back({res_re, res_im});
                            m_hunt = 1'b0;
                        end
                    end
                end else if (int'(sel_in) == part.size()) begin
                    if (part.size() == 0 && n0 == 2) begin
                        m_ov = 1'b1;
                        m_hunt = 1'b1;
                    end else begin
                        part.push_back({res_re, res_im});
                        if (part.size() == FL) push_frame = 1'b1;
                    end
                end else begin
                    m_se = 1'b1;
                    part.delete();
                    if (sel_in == 0 && n0 < 2) part.push_back({res_re, res_im});
                    else m_hunt = 1'b1;
                end
            end
            if (n0 > 0 && out_ready) begin
                rd_pos++;
                if (rd_pos == FL) begin
                    repeat (FL) void'(fq.pop_front());
                    rd_pos = 0;
                end
            end
            if (push_frame) begin
                foreach (part[i]) fq.push_back(part[i]);
                part.delete();
            end
        end
    end

    always @(negedge clk2) begin
        if (!rst) begin
            chk("out_valid", out_valid, fq.size() > 0);
            if (fq.size() > 0) begin
                chk("out_idx", out_idx, rd_pos);
                chk("out_re", out_re, fq[rd_pos][31:16]);
                chk("out_im", out_im, fq[rd_pos][15:0]);
                chk("out_last", out_last, rd_pos == FL - 1);
            end
            chk("seq_err", seq_err, m_se);
            chk("overflow", overflow, m_ov);
            if (out_valid && out_ready) begin
                log_q.push_back({out_last, out_idx, out_re, out_im});
                stamp_q.push_back(cyc);
            end
            if (seq_err) n_se++;
            if (overflow) n_ov++;
        end
    end

    task automatic send(input int s, input int r, input int i);
        res_valid = 1'b1;
        sel_in = SEL_W'(s);
        res_re = DW'(r);
        res_im = DW'(i);
        @(posedge clk2);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk2);
            #1;
        end
    endtask

    task automatic clear_stats();
        log_q.delete();
        stamp_q.delete();
        n_se = 0;
        n_ov = 0;
    endtask

    initial begin
        logic [35:0] e36;
        bit bubble;
        int thr;

        // reset state
        #5;
        chk("rst_valid", out_valid, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_re", out_re, 0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // 1: clean frame, re=10k, im=-k
        clear_stats();
        out_ready = 1'b1;
        for (int k = 0; k < FL; k++) begin
            if (k == FL - 1) chk("t1_valid_before", out_valid, 0);
            send(k, 10 * k, -k);
        end
        chk("t1_valid_after", out_valid, 1);
        idle(8);
        chk("t1_beats", log_q.size(), 5);
        for (int k = 0; k < FL && k < log_q.size(); k++) begin
            e36 = {k == FL - 1, SEL_W'(k), DW'(10 * k), DW'(-k)};
            chk("t1_beat", log_q[k], e36);
        end

        // 2: both banks fill, third frame dropped, then back-to-back drain
        clear_stats();
        out_ready = 1'b0;
        for (int f = 1; f <= 3; f++)
            for (int k = 0; k < FL; k++) send(k, 100 * f + k, f);
        idle(2);
        chk("t2_ov_count", n_ov, 1);
        chk("t2_se_count", n_se, 0);
        out_ready = 1'b1;
        idle(14);
        chk("t2_beats", log_q.size(), 10);
        bubble = 1'b0;
        for (int i = 0; i < 10 && i < log_q.size(); i++) begin
            chk("t2_re", log_q[i][31:16], (i < 5) ? 100 + i : 200 + i - 5);
            if (i > 0 && stamp_q[i] != stamp_q[i-1] + 1) bubble = 1'b1;
        end
        chk("t2_no_bubble", bubble, 0);

        // 3: 0,1,3 -> seq_err, then one clean frame
        clear_stats();
        send(0, 1, 1); send(1, 2, 2); send(3, 3, 3);
        idle(3);
        chk("t3_se", n_se, 1);
        chk("t3_no_out", log_q.size(), 0);
        for (int k = 0; k < FL; k++) send(k, 30 + k, 0);
        idle(8);
        chk("t3_beats", log_q.size(), 5);
        chk("t3_se_total", n_se, 1);

        // 4: 0,1,0,1,2,3,4 -> restart at second 0
        clear_stats();
        send(0, 50, 0); send(1, 51, 0);
        for (int k = 0; k < FL; k++) send(k, 60 + k, 0);
        idle(8);
        chk("t4_se", n_se, 1);
        chk("t4_beats", log_q.size(), 5);
        if (log_q.size() > 0) chk("t4_first_re", log_q[0][31:16], 60);

        // 5: after reset, leading 2,3,4 ignored, gaps between results
        rst = 1'b1;
        #1;
        rst = 1'b0;
        idle(1);
        clear_stats();
        for (int k = 2; k < FL; k++) begin
            send(k, 999, 0);
            idle($urandom_range(1, 3));
        end
        for (int k = 0; k < FL; k++) begin
            send(k, 70 + k, k);
            idle($urandom_range(1, 3));
        end
        idle(8);
        chk("t5_se", n_se, 0);
        chk("t5_beats", log_q.size(), 5);
        if (log_q.size() == 5) chk("t5_last_beat", log_q[4], {1'b1, 3'd4, 16'd74, 16'd4});

        // 6: reset mid-drain
        clear_stats();
        out_ready = 1'b0;
        for (int k = 0; k < FL; k++) send(k, 80 + k, 0);
        out_ready = 1'b1;
        idle(3);
        out_ready = 1'b0;
        chk("t6_accepted", log_q.size(), 3);
        rst = 1'b1;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_se", seq_err, 0);
        chk("t6_ov", overflow, 0);
        #1;
        rst = 1'b0;
        idle(1);
        clear_stats();
        out_ready = 1'b1;
        for (int k = 0; k < FL; k++) send(k, 90 + k, 0);
        idle(8);
        chk("t6_beats", log_q.size(), 5);
        if (log_q.size() > 0) chk("t6_first", log_q[0][34:16], {3'd0, 16'd90});

        // random traffic with bursts of backpressure
        begin
            int c;
            c = 0;
            for (int n = 0; n < 3000; n++) begin
                if (n % 250 == 0) begin
                    case ($urandom_range(0, 2))
                        0: thr = 90;
                        1: thr = 15;
                        default: thr = 60;
                    endcase
                end
                out_ready = ($urandom_range(0, 99) < thr);
                res_valid = ($urandom_range(0, 2) != 0);
                res_re = DW'($urandom);
                res_im = DW'($urandom);
                if ($urandom_range(0, 11) == 0) sel_in = SEL_W'($urandom_range(0, 7));
                else sel_in = SEL_W'(c);
                if (res_valid) c = (c + 1) % FL;
                @(posedge clk2);
                #1;
            end
            res_valid = 1'b0;
            out_ready = 1'b1;
            idle(15);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
